// File: rtl/syn_acortex_codec_init.sv
// syn_acortex_codec_init
//
// Configuration sequencer for the WM8731 codec. It sits upstream of the
// acortex I2C master. After a start pulse it programs the master's clock
// divider and device address once. Then, for each of the 11 ROM words, it
// writes the DATA register, triggers the transfer through STATUS and polls
// STATUS until the master is no longer busy. A NACK is retried up to
// P_MAX_RETRY times. Retry exhaustion or a poll timeout ends in a sticky
// error.
//
// Ports:
//   clk_ir         system clock, rising edge
//   rst_sync       synchronous active-high reset
//   init_start     start pulse, ignored unless idle
//   init_busy      sequence in progress
//   init_done      one-cycle pulse on successful completion
//   init_err       sticky error flag, cleared by the next accepted start
//   init_err_idx   ROM index of the failing word
//   i2cm_wr_en     local-bus write strobe
//   i2cm_rd_en     local-bus read strobe
//   i2cm_addr      local-bus register address
//   i2cm_wr_data   local-bus write data
//   i2cm_wr_valid  write acknowledge, one cycle after the strobe
//   i2cm_rd_valid  read acknowledge, one cycle after the strobe
//   i2cm_rd_data   read data; STATUS bit0 = busy, bit1 = nack

module syn_acortex_codec_init #(
    parameter int unsigned P_LB_ADDR_W    = 8,
    parameter int unsigned P_LB_DATA_W    = 16,
    parameter logic [7:0]  P_DEV_ADDR     = 8'h34,
    parameter logic [7:0]  P_CLK_DIV      = 8'hff,
    parameter int unsigned P_MAX_RETRY    = 3,
    parameter int unsigned P_POLL_GAP     = 16,
    parameter int unsigned P_POLL_TIMEOUT = 16'hffff,
    parameter logic [P_LB_ADDR_W-1:0] ACORTEX_I2CM_STATUS_REG_ADDR  = 'h00,
    parameter logic [P_LB_ADDR_W-1:0] ACORTEX_I2CM_ADDR_REG_ADDR    = 'h01,
    parameter logic [P_LB_ADDR_W-1:0] ACORTEX_I2CM_DATA_REG_ADDR    = 'h02,
    parameter logic [P_LB_ADDR_W-1:0] ACORTEX_I2CM_CLK_DIV_REG_ADDR = 'h03
) (
    input  logic                   clk_ir,
    input  logic                   rst_sync,
    input  logic                   init_start,
    output logic                   init_busy,
    output logic                   init_done,
    output logic                   init_err,
    output logic [3:0]             init_err_idx,
    output logic                   i2cm_wr_en,
    output logic                   i2cm_rd_en,
    output logic [P_LB_ADDR_W-1:0] i2cm_addr,
    output logic [P_LB_DATA_W-1:0] i2cm_wr_data,
    input  logic                   i2cm_wr_valid,
    input  logic                   i2cm_rd_valid,
    input  logic [P_LB_DATA_W-1:0] i2cm_rd_data
);

    localparam int unsigned RetryW  = (P_MAX_RETRY > 0) ? $clog2(P_MAX_RETRY + 1) : 1;
    localparam logic [3:0]  LastIdx = 4'd10;

    typedef enum logic [3:0] {
        StIdle,
        StWrClkdiv,
        StWrDev,
        StWrData,
        StTrig,
        StPollGap,
        StPollRd,
        StCheck,
        StDone,
        StErr
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [15:0]         poll_q, poll_d;
    logic [15:0]         gap_q, gap_d;
    logic                sent_q, sent_d;     // strobe of the current access already issued
    logic [1:0]          status_q, status_d; // {nack, busy}
    logic                err_q, err_d;
    logic [3:0]          err_idx_q, err_idx_d;
    logic [15:0]         poll_inc;
    logic                unused_rd_data;

    assign unused_rd_data = ^i2cm_rd_data[P_LB_DATA_W-1:2];

    // WM8731 control words: {reg[6:0], data[8:0]}
    function automatic logic [15:0] rom_word(input logic [3:0] i);
        logic [15:0] w;
        case (i)
            4'd0:    w = 16'h1E00;
            4'd1:    w = 16'h0C00;
            4'd2:    w = 16'h0017;
            4'd3:    w = 16'h0217;
            4'd4:    w = 16'h0479;
            4'd5:    w = 16'h0679;
            4'd6:    w = 16'h0812;
            4'd7:    w = 16'h0A00;
            4'd8:    w = 16'h0E02;
            4'd9:    w = 16'h1000;
            4'd10:   w = 16'h1201;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            retry_q   <= '0;
            poll_q    <= '0;
            gap_q     <= '0;
            sent_q    <= 1'b0;
            status_q  <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            poll_q    <= poll_d;
            gap_q     <= gap_d;
            sent_q    <= sent_d;
            status_q  <= status_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign init_err     = err_q;
    assign init_err_idx = err_idx_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        poll_d       = poll_q;
        gap_d        = gap_q;
        sent_d       = sent_q;
        status_d     = status_q;
        err_d        = err_q;
        err_idx_d    = err_idx_q;
        poll_inc     = (poll_q == 16'hffff) ? poll_q : poll_q + 16'd1;
        init_busy    = 1'b1;
        init_done    = 1'b0;
        i2cm_wr_en   = 1'b0;
        i2cm_rd_en   = 1'b0;
        i2cm_addr    = '0;
        i2cm_wr_data = '0;

        unique case (state_q)
            StIdle: begin
                init_busy = 1'b0;
                sent_d    = 1'b0;
                if (init_start) begin
                    state_d   = StWrClkdiv;
                    idx_d     = '0;
                    retry_d   = '0;
                    poll_d    = '0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                end
            end
            StWrClkdiv: begin
                i2cm_addr    = ACORTEX_I2CM_CLK_DIV_REG_ADDR;
                i2cm_wr_data = P_LB_DATA_W'(P_CLK_DIV);
                i2cm_wr_en   = ~sent_q;
                sent_d       = 1'b1;
                if (sent_q && i2cm_wr_valid) begin
                    sent_d  = 1'b0;
                    state_d = StWrDev;
                end
            end
            StWrDev: begin
                i2cm_addr    = ACORTEX_I2CM_ADDR_REG_ADDR;
                i2cm_wr_data = P_LB_DATA_W'(P_DEV_ADDR);
                i2cm_wr_en   = ~sent_q;
                sent_d       = 1'b1;
                if (sent_q && i2cm_wr_valid) begin
                    sent_d  = 1'b0;
                    state_d = StWrData;
                end
            end
            StWrData: begin
                i2cm_addr    = ACORTEX_I2CM_DATA_REG_ADDR;
                i2cm_wr_data = P_LB_DATA_W'(rom_word(idx_q));
                i2cm_wr_en   = ~sent_q;
                sent_d       = 1'b1;
                if (sent_q && i2cm_wr_valid) begin
                    sent_d  = 1'b0;
                    state_d = StTrig;
                end
            end
            StTrig: begin
                // Writing STATUS starts the transfer and clears the master's nack flag
                i2cm_addr    = ACORTEX_I2CM_STATUS_REG_ADDR;
                i2cm_wr_data = '0;
                i2cm_wr_en   = ~sent_q;
                sent_d       = 1'b1;
                if (sent_q && i2cm_wr_valid) begin
                    sent_d  = 1'b0;
                    gap_d   = '0;
                    state_d = StPollGap;
                end
            end
            StPollGap: begin
                if (32'(gap_q) + 32'd1 >= P_POLL_GAP) begin
                    gap_d   = '0;
                    state_d = StPollRd;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            StPollRd: begin
                i2cm_addr  = ACORTEX_I2CM_STATUS_REG_ADDR;
                i2cm_rd_en = ~sent_q;
                sent_d     = 1'b1;
                if (sent_q && i2cm_rd_valid) begin
                    sent_d   = 1'b0;
                    status_d = i2cm_rd_data[1:0];
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (status_q[0]) begin
                    poll_d  = poll_inc;
                    state_d = (32'(poll_inc) >= P_POLL_TIMEOUT) ? StErr : StPollGap;
                end else if (!status_q[1]) begin
                    idx_d   = idx_q + 4'd1;
                    retry_d = '0;
                    poll_d  = '0;
                    state_d = (idx_q == LastIdx) ? StDone : StWrData;
                end else if (32'(retry_q) < P_MAX_RETRY) begin
                    retry_d = retry_q + RetryW'(1);
                    poll_d  = '0;
                    state_d = StWrData;
                end else begin
                    state_d = StErr;
                end
            end
            StDone: begin
                init_busy = 1'b0;
                init_done = 1'b1;
                state_d   = StIdle;
            end
            StErr: begin
                init_busy = 1'b0;
                err_d     = 1'b1;
                err_idx_d = idx_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_syn_acortex_codec_init.sv
// Directed testbench for syn_acortex_codec_init with a behavioural I2C
// master on the local bus. The master model ACKs every write and read one
// cycle after the strobe. It reports busy on the first status read after
// each trigger, and it can be told to NACK a chosen word or to hold busy
// forever.

module tb_syn_acortex_codec_init;

    localparam logic [7:0] A_STATUS = 8'h00;
    localparam logic [7:0] A_DEV    = 8'h01;
    localparam logic [7:0] A_DATA   = 8'h02;
    localparam logic [7:0] A_CLK    = 8'h03;

    logic        clk = 1'b0;
    logic        rst_sync;
    logic        init_start;
    logic        init_busy, init_done, init_err;
    logic [3:0]  init_err_idx;
    logic        i2cm_wr_en, i2cm_rd_en;
    logic [7:0]  i2cm_addr;
    logic [15:0] i2cm_wr_data;
    logic        i2cm_wr_valid, i2cm_rd_valid;
    logic [15:0] i2cm_rd_data;

    always #5 clk = ~clk;

    syn_acortex_codec_init #(
        .P_LB_ADDR_W                  (8),
        .P_LB_DATA_W                  (16),
        .P_DEV_ADDR                   (8'h34),
        .P_CLK_DIV                    (8'hff),
        .P_MAX_RETRY                  (3),
        .P_POLL_GAP                   (4),
        .P_POLL_TIMEOUT               (8),
        .ACORTEX_I2CM_STATUS_REG_ADDR (A_STATUS),
        .ACORTEX_I2CM_ADDR_REG_ADDR   (A_DEV),
        .ACORTEX_I2CM_DATA_REG_ADDR   (A_DATA),
        .ACORTEX_I2CM_CLK_DIV_REG_ADDR(A_CLK)
    ) u_dut (
        .clk_ir       (clk),
        .rst_sync     (rst_sync),
        .init_start   (init_start),
        .init_busy    (init_busy),
        .init_done    (init_done),
        .init_err     (init_err),
        .init_err_idx (init_err_idx),
        .i2cm_wr_en   (i2cm_wr_en),
        .i2cm_rd_en   (i2cm_rd_en),
        .i2cm_addr    (i2cm_addr),
        .i2cm_wr_data (i2cm_wr_data),
        .i2cm_wr_valid(i2cm_wr_valid),
        .i2cm_rd_valid(i2cm_rd_valid),
        .i2cm_rd_data (i2cm_rd_data)
    );

    logic [15:0] rom [0:10] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201};

    int          n_checks = 0;
    int          n_pass   = 0;

    // master model state and logs
    int          clk_cnt, dev_cnt, trig_cnt, rd_cnt, done_cnt, viol;
    logic [15:0] clk_data, dev_data;
    logic [15:0] data_q [$];
    int          attempts [0:10];
    int          cur_word, nack_word, nack_times, polls;
    bit          hold_busy, cur_nack;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    task automatic clear_logs();
        clk_cnt = 0; dev_cnt = 0; trig_cnt = 0; rd_cnt = 0; done_cnt = 0;
        clk_data = '0; dev_data = '0;
        data_q.delete();
        for (int i = 0; i < 11; i++) attempts[i] = 0;
        cur_word = -1; nack_word = -1; nack_times = 0; polls = 0;
        hold_busy = 1'b0; cur_nack = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        check({tag, "_busy_rise"}, init_busy, 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (init_busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_finish"}, init_busy, 0);
        repeat (3) @(negedge clk);
    endtask

    // I2C master model: sample strobes mid-cycle, answer one cycle later
    initial begin
        logic        pw, pr, prev_strobe;
        logic [15:0] status;
        i2cm_wr_valid = 1'b0;
        i2cm_rd_valid = 1'b0;
        i2cm_rd_data  = '0;
        prev_strobe   = 1'b0;
        viol          = 0;
        status        = '0;
        forever begin
            @(negedge clk);
            pw = i2cm_wr_en;
            pr = i2cm_rd_en;
            if (pw && pr) viol++;
            if ((pw || pr) && prev_strobe) viol++;
            prev_strobe = pw || pr;
            if (init_done) begin
                done_cnt++;
                if (init_busy) viol++;
            end
            if (pw) begin
                if (i2cm_addr == A_CLK) begin
                    clk_cnt++; clk_data = i2cm_wr_data;
                end else if (i2cm_addr == A_DEV) begin
                    dev_cnt++; dev_data = i2cm_wr_data;
                end else if (i2cm_addr == A_DATA) begin
                    data_q.push_back(i2cm_wr_data);
                    for (int i = 0; i < 11; i++) if (rom[i] == i2cm_wr_data) cur_word = i;
                    if (cur_word >= 0) attempts[cur_word]++;
                end else if (i2cm_addr == A_STATUS) begin
                    trig_cnt++;
                    polls    = 0;
                    cur_nack = (cur_word >= 0) && (cur_word == nack_word) &&
                               (attempts[cur_word] <= nack_times);
                end
            end
            if (pr) begin
                rd_cnt++;
                if (hold_busy || polls == 0) status = 16'h0001;
                else status = cur_nack ? 16'h0002 : 16'h0000;
                polls++;
            end
            @(posedge clk);
            #1;
            i2cm_wr_valid = pw;
            i2cm_rd_valid = pr;
            if (pr) i2cm_rd_data = status;
        end
    end

    initial begin
        rst_sync   = 1'b1;
        init_start = 1'b0;
        clear_logs();
        repeat (3) @(negedge clk);
        check("rst_wr_en", i2cm_wr_en, 0);
        check("rst_rd_en", i2cm_rd_en, 0);
        check("rst_addr", i2cm_addr, 0);
        check("rst_wr_data", i2cm_wr_data, 0);
        check("rst_busy", init_busy, 0);
        check("rst_done", init_done, 0);
        check("rst_err", init_err, 0);
        check("rst_err_idx", init_err_idx, 0);
        rst_sync = 1'b0;
        repeat (2) @(negedge clk);

        // clean run
        clear_logs();
        pulse_start("clean");
        wait_idle(2000, "clean");
        check("clean_done_cnt", done_cnt, 1);
        check("clean_err", init_err, 0);
        check("clean_clk_cnt", clk_cnt, 1);
        check("clean_clk_data", clk_data, 16'h00ff);
        check("clean_dev_cnt", dev_cnt, 1);
        check("clean_dev_data", dev_data, 16'h0034);
        check("clean_data_cnt", data_q.size(), 11);
        check("clean_trig_cnt", trig_cnt, 11);
        for (int i = 0; i < 11; i++)
            check($sformatf("clean_data%0d", i),
                  (i < data_q.size()) ? data_q[i] : 16'hdead, rom[i]);

        // NACK word 4 twice, then ACK
        clear_logs();
        nack_word  = 4;
        nack_times = 2;
        pulse_start("nack4");
        wait_idle(2000, "nack4");
        check("nack4_attempts", attempts[4], 3);
        check("nack4_data_cnt", data_q.size(), 13);
        check("nack4_err", init_err, 0);
        check("nack4_done_cnt", done_cnt, 1);

        // NACK word 2 on every attempt
        clear_logs();
        nack_word  = 2;
        nack_times = 100;
        pulse_start("nack2");
        wait_idle(2000, "nack2");
        check("nack2_attempts", attempts[2], 4);
        check("nack2_word3", attempts[3], 0);
        check("nack2_data_cnt", data_q.size(), 6);
        check("nack2_err", init_err, 1);
        check("nack2_err_idx", init_err_idx, 2);
        check("nack2_done_cnt", done_cnt, 0);

        // busy held forever: poll timeout
        clear_logs();
        hold_busy = 1'b1;
        pulse_start("tmo");
        check("tmo_err_cleared", init_err, 0);
        wait_idle(2000, "tmo");
        check("tmo_rd_cnt", rd_cnt, 8);
        check("tmo_err", init_err, 1);
        check("tmo_err_idx", init_err_idx, 0);
        check("tmo_data_cnt", data_q.size(), 1);

        // reset during POLL_GAP of word 5
        clear_logs();
        pulse_start("rstmid");
        begin
            int k = 0;
            while (trig_cnt < 6 && k < 2000) begin
                @(negedge clk);
                k++;
            end
        end
        check("rstmid_reach_w5", trig_cnt, 6);
        @(negedge clk);
        rst_sync = 1'b1;
        @(negedge clk);
        rst_sync = 1'b0;
        check("rstmid_outs", {i2cm_wr_en, i2cm_rd_en, init_busy, init_done, i2cm_addr,
                              i2cm_wr_data}, 0);
        repeat (4) @(negedge clk);
        clear_logs();
        repeat (5) @(negedge clk);
        check("rstmid_no_restart", clk_cnt + data_q.size(), 0);
        pulse_start("restart");
        wait_idle(2000, "restart");
        check("restart_clk_cnt", clk_cnt, 1);
        check("restart_first", (data_q.size() > 0) ? data_q[0] : 16'hdead, 16'h1E00);
        check("restart_data_cnt", data_q.size(), 11);
        check("restart_done_cnt", done_cnt, 1);

        // start while busy, and start coincident with DONE
        clear_logs();
        pulse_start("ign");
        repeat (30) @(negedge clk);
        pulse_start("ign_mid");
        begin
            int k = 0;
            while (!init_done && k < 2000) begin
                @(negedge clk);
                k++;
            end
        end
        check("ign_saw_done", init_done, 1);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        check("ign_busy_after_done", init_busy, 0);
        repeat (10) @(negedge clk);
        check("ign_busy_idle", init_busy, 0);
        check("ign_clk_cnt", clk_cnt, 1);
        check("ign_data_cnt", data_q.size(), 11);
        check("ign_done_cnt", done_cnt, 1);

        check("protocol_viol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
